// File: rtl/key_debounce_if.sv
// Signal bundle between a raw pushbutton source and the key debouncer.
// The slave side is the debouncer. The master side drives key_raw and consumes the conditioned outputs.
interface key_debounce_if;
  logic key_raw;
  logic key_clean;
  logic press_pulse;
  logic release_pulse;
  logic busy;

  modport master (
    output key_raw,
    input  key_clean,
    input  press_pulse,
    input  release_pulse,
    input  busy
  );

  modport slave (
    input  key_raw,
    output key_clean,
    output press_pulse,
    output release_pulse,
    output busy
  );
endinterface

// File: rtl/key_debounce.sv
// Pushbutton conditioner: two-flop synchroniser, then a four-state stability filter.
// The filter produces the registered clean level, the press/release strobes and a busy flag.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_WIDTH       = 20
) (
  input  logic          clock,
  input  logic          reset,
  key_debounce_if.slave key
);

  localparam logic [1:0] IDLE_HIGH  = 2'b00;
  localparam logic [1:0] CHECK_LOW  = 2'b01;
  localparam logic [1:0] HELD_LOW   = 2'b10;
  localparam logic [1:0] CHECK_HIGH = 2'b11;

  localparam logic [CNT_WIDTH-1:0] TERMINAL = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                 sync_ff1, sync_ff2;
  logic [1:0]           state, state_nxt;
  logic [CNT_WIDTH-1:0] count, count_nxt;
  logic                 key_clean_q, press_q, release_q, busy_q;

  // NOTE: the synchroniser resets to 1 (key released), so a reset never fakes a press.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_ff1 <= 1'b1;
      sync_ff2 <= 1'b1;
    end else begin
      sync_ff1 <= key.key_raw;
      sync_ff2 <= sync_ff1;
    end
  end

  // A reversal during a CHECK state drops back with count cleared, so no partial credit is kept.
  always_comb begin
    // NOTE: defaults first keep this block free of inferred latches.
    state_nxt = state;
    count_nxt = count;
    case (state)
      IDLE_HIGH:
        if (!sync_ff2) begin
          state_nxt = CHECK_LOW;
          count_nxt = '0;
        end
      CHECK_LOW:
        if (sync_ff2) begin
          state_nxt = IDLE_HIGH;
          count_nxt = '0;
        end else if (count == TERMINAL) begin
          state_nxt = HELD_LOW;
          count_nxt = '0;
        end else begin
          count_nxt = count + 1'b1;
        end
      HELD_LOW:
        if (sync_ff2) begin
          state_nxt = CHECK_HIGH;
          count_nxt = '0;
        end
      CHECK_HIGH:
        if (!sync_ff2) begin
          state_nxt = HELD_LOW;
          count_nxt = '0;
        end else if (count == TERMINAL) begin
          state_nxt = IDLE_HIGH;
          count_nxt = '0;
        end else begin
          count_nxt = count + 1'b1;
        end
      default: begin
        state_nxt = IDLE_HIGH;
        count_nxt = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state, so they register in the same edge as the transition.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE_HIGH;
      count       <= '0;
      key_clean_q <= 1'b1;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state       <= state_nxt;
      count       <= count_nxt;
      key_clean_q <= (state_nxt == IDLE_HIGH) || (state_nxt == CHECK_LOW);
      busy_q      <= (state_nxt == CHECK_LOW) || (state_nxt == CHECK_HIGH);
      press_q     <= (state == CHECK_LOW)  && (state_nxt == HELD_LOW);
      release_q   <= (state == CHECK_HIGH) && (state_nxt == IDLE_HIGH);
    end
  end

  assign key.key_clean     = key_clean_q;
  assign key.press_pulse   = press_q;
  assign key.release_pulse = release_q;
  assign key.busy          = busy_q;

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce with a short debounce window.
// An independent run-length model predicts the outputs for every cycle through a scoreboard queue.
module tb_key_debounce;

  localparam int D  = 8;
  localparam int CW = 4;

  typedef struct packed {
    logic clean;
    logic press;
    logic rel;
    logic busy;
  } exp_t;

  logic clock = 1'b0;
  logic reset;

  key_debounce_if bus ();

  key_debounce #(.DEBOUNCE_CYCLES(D), .CNT_WIDTH(CW)) dut (
    .clock (clock),
    .reset (reset),
    .key   (bus)
  );

  always #5 clock = ~clock;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];

  // Reference model: a two-stage delay feeding a run-length counter.
  // The level flips once the synchronised input has disagreed for D+1 consecutive samples.
  logic m_ff1, m_ff2, m_clean;
  int   m_run;

  int   edge_n = 0;
  int   press_cnt, rel_cnt, busy_cnt, press_edge, rel_edge, fall_edge;
  logic clean_prev;
  int   t0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ff1      = 1'b1;
    m_ff2      = 1'b1;
    m_clean    = 1'b1;
    m_run      = 0;
    clean_prev = 1'b1;
    sb.delete();
  endtask

  task automatic clr();
    press_cnt  = 0;
    rel_cnt    = 0;
    busy_cnt   = 0;
    press_edge = -1;
    rel_edge   = -1;
    fall_edge  = -1;
  endtask

  // Called at a falling edge: drive key_raw, clock once, predict, then compare #1 after the edge.
  task automatic step(input logic k);
    exp_t e, q;
    bus.key_raw = k;
    @(posedge clock);
    e.press = 1'b0;
    e.rel   = 1'b0;
    if (m_ff2 != m_clean) begin
      m_run++;
      if (m_run == D + 1) begin
        m_clean = ~m_clean;
        e.press = ~m_clean;
        e.rel   = m_clean;
        m_run   = 0;
      end
    end else begin
      m_run = 0;
    end
    m_ff2   = m_ff1;
    m_ff1   = k;
    e.clean = m_clean;
    e.busy  = (m_run != 0);
    sb.push_back(e);
    #1;
    q = sb.pop_front();
    check("key_clean", 32'(bus.key_clean), 32'(q.clean));
    check("press_pulse", 32'(bus.press_pulse), 32'(q.press));
    check("release_pulse", 32'(bus.release_pulse), 32'(q.rel));
    check("busy", 32'(bus.busy), 32'(q.busy));
    check("pulse_excl", 32'(bus.press_pulse & bus.release_pulse), 32'd0);
    if (bus.press_pulse) begin
      press_cnt++;
      press_edge = edge_n;
    end
    if (bus.release_pulse) begin
      rel_cnt++;
      rel_edge = edge_n;
    end
    if (bus.busy) busy_cnt++;
    if (clean_prev && !bus.key_clean) fall_edge = edge_n;
    clean_prev = bus.key_clean;
    edge_n++;
    @(negedge clock);
  endtask

  initial begin
    reset       = 1'b0;
    bus.key_raw = 1'b1;
    model_reset();
    clr();
    repeat (3) @(negedge clock);
    check("rst_key_clean", 32'(bus.key_clean), 32'd1);
    check("rst_press", 32'(bus.press_pulse), 32'd0);
    check("rst_release", 32'(bus.release_pulse), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    reset = 1'b1;

    // Idle after reset: nothing moves for 50 cycles.
    repeat (50) step(1'b1);
    check("t1_press_cnt", 32'(press_cnt), 32'd0);
    check("t1_rel_cnt", 32'(rel_cnt), 32'd0);
    check("t1_busy_cnt", 32'(busy_cnt), 32'd0);

    // Clean press: falls at edge D+2, busy for D cycles, then a clean release.
    clr();
    t0 = edge_n;
    repeat (20) step(1'b0);
    check("t2_press_cnt", 32'(press_cnt), 32'd1);
    check("t2_press_edge", 32'(press_edge - t0), 32'(D + 2));
    check("t2_fall_edge", 32'(fall_edge - t0), 32'(D + 2));
    check("t2_busy_cnt", 32'(busy_cnt), 32'(D));
    clr();
    t0 = edge_n;
    repeat (20) step(1'b1);
    check("t2_rel_cnt", 32'(rel_cnt), 32'd1);
    check("t2_rel_edge", 32'(rel_edge - t0), 32'(D + 2));

    // Short glitch is rejected.
    clr();
    repeat (5) step(1'b0);
    repeat (20) step(1'b1);
    check("t3_press_cnt", 32'(press_cnt), 32'd0);
    check("t3_rel_cnt", 32'(rel_cnt), 32'd0);
    check("t3_clean_end", 32'(bus.key_clean), 32'd1);
    check("t3_busy_end", 32'(bus.busy), 32'd0);

    // Bouncy release: exactly one release, D+2 edges after the final rise.
    clr();
    repeat (12) step(1'b0);
    check("t4_press_cnt", 32'(press_cnt), 32'd1);
    clr();
    for (int i = 0; i < 4; i++) begin
      repeat (3) step(1'b1);
      repeat (3) step(1'b0);
    end
    t0 = edge_n;
    repeat (20) step(1'b1);
    check("t4_rel_cnt", 32'(rel_cnt), 32'd1);
    check("t4_rel_edge", 32'(rel_edge - t0), 32'(D + 2));
    check("t4_press_cnt2", 32'(press_cnt), 32'd0);

    // Reset in the middle of CHECK_LOW aborts timing immediately.
    clr();
    repeat (7) step(1'b0);
    check("t5_count_pre", 32'(dut.count), 32'd4);
    check("t5_busy_pre", 32'(bus.busy), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("t5_key_clean", 32'(bus.key_clean), 32'd1);
    check("t5_busy", 32'(bus.busy), 32'd0);
    check("t5_press", 32'(bus.press_pulse), 32'd0);
    check("t5_count", 32'(dut.count), 32'd0);
    model_reset();
    repeat (2) @(negedge clock);
    bus.key_raw = 1'b1;
    reset       = 1'b1;
    repeat (20) step(1'b1);
    check("t5_press_cnt", 32'(press_cnt), 32'd0);

    // Key held low through reset release is debounced again from IDLE_HIGH.
    clr();
    bus.key_raw = 1'b0;
    reset       = 1'b0;
    repeat (2) @(negedge clock);
    check("t6_rst_clean", 32'(bus.key_clean), 32'd1);
    model_reset();
    reset = 1'b1;
    t0    = edge_n;
    repeat (20) step(1'b0);
    check("t6_press_cnt", 32'(press_cnt), 32'd1);
    check("t6_press_edge", 32'(press_edge - t0), 32'(D + 2));
    check("t6_fall_edge", 32'(fall_edge - t0), 32'(D + 2));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
